// File: rtl/sdram_responder.sv
// SDRAM device-side responder: decodes controller commands, models a small
// banked memory with CAS-latency read return, and flags protocol misuse.
`timescale 1ns/1ps
module sdram_responder #(
  parameter int ROW_WIDTH  = 13,
  parameter int COL_WIDTH  = 9,
  parameter int BANK_WIDTH = 2,
  parameter int TRCD       = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clock_enable,
  input  logic                  cs_n,
  input  logic                  ras_n,
  input  logic                  cas_n,
  input  logic                  we_n,
  input  logic [ROW_WIDTH-1:0]  addr,
  input  logic [BANK_WIDTH-1:0] bank_addr,
  input  logic                  data_mask_low,
  input  logic                  data_mask_high,
  input  logic [15:0]           data_in,
  output logic [15:0]           data_out,
  output logic                  data_oe,
  output logic                  init_done,
  output logic                  protocol_error,
  output logic [2:0]            error_code,
  output logic [15:0]           refresh_count
);

  localparam int NB        = 1 << BANK_WIDTH;
  localparam int CNT_W     = $clog2(TRCD + 1);
  localparam int MEM_AW    = BANK_WIDTH + 8;
  localparam int MEM_DEPTH = 1 << MEM_AW;
  localparam logic [CNT_W-1:0] TRCD_C = CNT_W'(TRCD);

  typedef enum logic [1:0] {WAIT_PALL, WAIT_REF, WAIT_MRS, READY} state_t;

  state_t state_reg, state_next;
  logic   ref_seen_reg, ref_seen_next;
  logic   cl3_reg;

  // Command decode: anything without CKE high and CS low is a NOP
  logic       cmd_en;
  logic [2:0] cmd;
  logic       is_act, is_rd, is_wr, is_pre, is_ref, is_mrs, is_bad;
  assign cmd_en = clock_enable & ~cs_n;
  assign cmd    = {ras_n, cas_n, we_n};
  assign is_act = cmd_en && (cmd == 3'b011);
  assign is_rd  = cmd_en && (cmd == 3'b101);
  assign is_wr  = cmd_en && (cmd == 3'b100);
  assign is_pre = cmd_en && (cmd == 3'b010);
  assign is_ref = cmd_en && (cmd == 3'b001);
  assign is_mrs = cmd_en && (cmd == 3'b000);
  assign is_bad = cmd_en && (cmd == 3'b110);

  // Per-bank state, gathered into vectors for the selected-bank lookup
  logic [NB-1:0]                bank_active;
  logic [NB-1:0][ROW_WIDTH-1:0] bank_row;
  logic [NB-1:0][CNT_W-1:0]     bank_since;

  logic                 ready, sel_active, act_ok, rw_ok, rd_fire, wr_fire;
  logic                 mrs_ok, ref_ok;
  logic [ROW_WIDTH-1:0] sel_row;
  logic [CNT_W-1:0]     sel_since;
  logic [COL_WIDTH-1:0] col_addr;
  logic [MEM_AW-1:0]    mem_idx;

  assign ready      = (state_reg == READY);
  assign sel_active = bank_active[bank_addr];
  assign sel_row    = bank_row[bank_addr];
  assign sel_since  = bank_since[bank_addr];
  assign act_ok     = is_act && ready && !sel_active;
  assign rw_ok      = (is_rd || is_wr) && ready && sel_active;
  assign rd_fire    = is_rd && rw_ok;
  assign wr_fire    = is_wr && rw_ok;
  assign mrs_ok     = is_mrs && ((addr[6:4] == 3'd2) || (addr[6:4] == 3'd3)) && (addr[2:0] == 3'b000);
  assign ref_ok     = is_ref && !(|bank_active);
  assign col_addr   = addr[COL_WIDTH-1:0];
  // Only the low row/column nibbles select storage; the rest alias
  assign mem_idx    = {bank_addr, sel_row[3:0], col_addr[3:0]};

  logic unused_bits;
  assign unused_bits = ^{sel_row[ROW_WIDTH-1:4], col_addr[COL_WIDTH-1:4]};

  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_bank
      logic                 active_reg;
      logic [ROW_WIDTH-1:0] row_reg;
      logic [CNT_W-1:0]     since_reg;
      logic                 hit;
      assign hit = (bank_addr == BANK_WIDTH'(gi));

      // Bank open/close tracking; since_reg counts edges after ACT, saturating
      always_ff @(posedge clk) begin
        if (rst) begin
          active_reg <= 1'b0;
          row_reg    <= '0;
          since_reg  <= '0;
        end else if (act_ok && hit) begin
          active_reg <= 1'b1;
          row_reg    <= addr;
          since_reg  <= CNT_W'(1);
        end else begin
          if (is_pre && (addr[10] || hit)) active_reg <= 1'b0;
          if (since_reg != TRCD_C) since_reg <= since_reg + 1'b1;
        end
      end

      assign bank_active[gi] = active_reg;
      assign bank_row[gi]    = row_reg;
      assign bank_since[gi]  = since_reg;
    end
  endgenerate

  // Error classification for the command on this edge
  logic       err_hit;
  logic [2:0] err_now;
  always_comb begin
    err_hit = 1'b1;
    err_now = 3'd0;
    if (is_bad)                                      err_now = 3'd7;
    else if ((is_act || is_rd || is_wr) && !ready)   err_now = 3'd1;
    else if (is_mrs && !mrs_ok)                      err_now = 3'd2;
    else if (is_act && sel_active)                   err_now = 3'd3;
    else if ((is_rd || is_wr) && !sel_active)        err_now = 3'd4;
    else if (rw_ok && (sel_since < TRCD_C))          err_now = 3'd5;
    else if (is_ref && !ref_ok)                      err_now = 3'd6;
    else if (wr_fire && data_oe)                     err_now = 3'd0;
    else                                             err_hit = 1'b0;
  end

  // Init sequence state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= WAIT_PALL;
      ref_seen_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      ref_seen_reg <= ref_seen_next;
    end
  end

  // Init sequence: precharge-all, two refreshes, then a valid mode register set
  always_comb begin
    state_next    = state_reg;
    ref_seen_next = ref_seen_reg;
    case (state_reg)
      WAIT_PALL: if (is_pre && addr[10]) state_next = WAIT_REF;
      WAIT_REF: begin
        if (is_ref) begin
          if (ref_seen_reg) begin
            state_next    = WAIT_MRS;
            ref_seen_next = 1'b0;
          end else begin
            ref_seen_next = 1'b1;
          end
        end
      end
      WAIT_MRS:  if (mrs_ok) state_next = READY;
      default:   state_next = READY;
    endcase
  end

  // Mode register (CAS latency 2 or 3), sticky first-error capture, refresh counter
  always_ff @(posedge clk) begin
    if (rst) begin
      cl3_reg        <= 1'b0;
      protocol_error <= 1'b0;
      error_code     <= 3'd0;
      refresh_count  <= 16'd0;
    end else begin
      if (mrs_ok) cl3_reg <= addr[4];
      if (err_hit && !protocol_error) begin
        protocol_error <= 1'b1;
        error_code     <= err_now;
      end
      if (ref_ok) refresh_count <= refresh_count + 16'd1;
    end
  end

  // Storage with per-byte write masks; contents survive reset
  logic [7:0] mem_lo [MEM_DEPTH];
  logic [7:0] mem_hi [MEM_DEPTH];
  always_ff @(posedge clk) begin
    if (wr_fire && !rst) begin
      if (!data_mask_low)  mem_lo[mem_idx] <= data_in[7:0];
      if (!data_mask_high) mem_hi[mem_idx] <= data_in[15:8];
    end
  end

  // Read return pipeline: slot 0 is the bus; a READ loads slot CL-1
  logic [2:0]       pipe_valid_reg;
  logic [2:0][15:0] pipe_data_reg;
  logic [1:0]       load_slot;
  assign load_slot = cl3_reg ? 2'd2 : 2'd1;

  // Valid bits shift toward the bus and are flushed by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_valid_reg <= '0;
    end else begin
      pipe_valid_reg <= {1'b0, pipe_valid_reg[2:1]};
      if (rd_fire) pipe_valid_reg[load_slot] <= 1'b1;
    end
  end

  // Data slots shift alongside; the word is fetched at the READ edge
  always_ff @(posedge clk) begin
    pipe_data_reg <= {16'd0, pipe_data_reg[2], pipe_data_reg[1]};
    if (rd_fire) pipe_data_reg[load_slot] <= {mem_hi[mem_idx], mem_lo[mem_idx]};
  end

  assign data_oe   = pipe_valid_reg[0];
  assign data_out  = data_oe ? pipe_data_reg[0] : 16'd0;
  assign init_done = ready;

endmodule

// File: tb/tb_sdram_responder.sv
// Scoreboard bench for sdram_responder: reads push expected words with their
// due cycle; a negedge monitor pops and compares whenever data is due.
`timescale 1ns/1ps
module tb_sdram_responder;

  localparam logic [2:0] C_NOP = 3'b111, C_ACT = 3'b011, C_RD  = 3'b101, C_WR = 3'b100;
  localparam logic [2:0] C_PRE = 3'b010, C_REF = 3'b001, C_MRS = 3'b000;

  logic        clk = 1'b0, rst = 1'b0;
  logic        clock_enable = 1'b0, cs_n = 1'b1, ras_n = 1'b1, cas_n = 1'b1, we_n = 1'b1;
  logic [12:0] addr = '0;
  logic [1:0]  bank_addr = '0;
  logic        data_mask_low = 1'b0, data_mask_high = 1'b0;
  logic [15:0] data_in = '0;
  logic [15:0] data_out, refresh_count;
  logic        data_oe, init_done, protocol_error;
  logic [2:0]  error_code;

  sdram_responder dut (
    .clk(clk), .rst(rst), .clock_enable(clock_enable), .cs_n(cs_n),
    .ras_n(ras_n), .cas_n(cas_n), .we_n(we_n), .addr(addr), .bank_addr(bank_addr),
    .data_mask_low(data_mask_low), .data_mask_high(data_mask_high),
    .data_in(data_in), .data_out(data_out), .data_oe(data_oe),
    .init_done(init_done), .protocol_error(protocol_error),
    .error_code(error_code), .refresh_count(refresh_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_checks = 0, n_errors = 0;
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  typedef struct { int due; logic [15:0] data; } rd_t;
  rd_t         sb[$];
  logic [15:0] exp_mem [1024];
  logic [12:0] model_row [4];
  int          mcl = 2;
  bit          mon_en = 1'b0;

  // Every negedge: either a read is due (must be on the bus) or the bus is idle
  always @(negedge clk) begin
    rd_t e;
    if (mon_en) begin
      if (sb.size() > 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        check_eq("rd_oe", data_oe, 1);
        check_eq("rd_data", data_out, e.data);
        $display("cycle %0d read return data=%h expected=%h", cyc, data_out, e.data);
      end else begin
        check_eq("idle_oe", data_oe, 0);
        check_eq("idle_dout", data_out, 0);
      end
    end
  end

  task automatic drive(input string name, input logic [2:0] c, input logic [1:0] b,
                       input logic [12:0] a, input logic [15:0] d, input logic ml, input logic mh);
    @(negedge clk);
    clock_enable = 1'b1; cs_n = 1'b0; {ras_n, cas_n, we_n} = c;
    bank_addr = b; addr = a; data_in = d; data_mask_low = ml; data_mask_high = mh;
    $display("cycle %0d cmd %s bank=%0d addr=%h data=%h", cyc + 1, name, b, a, d);
  endtask

  task automatic nop(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cs_n = 1'b1; {ras_n, cas_n, we_n} = C_NOP;
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1; cs_n = 1'b1; {ras_n, cas_n, we_n} = C_NOP;
    sb.delete();
    mcl = 2;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic do_act(input logic [1:0] b, input logic [12:0] row);
    drive("ACT", C_ACT, b, row, 16'h0, 1'b0, 1'b0);
    model_row[b] = row;
  endtask

  task automatic do_mrs(input logic [12:0] a);
    drive("MRS", C_MRS, 2'd0, a, 16'h0, 1'b0, 1'b0);
    if ((a[6:4] == 3'd2 || a[6:4] == 3'd3) && a[2:0] == 3'd0) mcl = int'(a[6:4]);
  endtask

  task automatic do_write(input logic [1:0] b, input logic [3:0] col, input logic [15:0] d,
                          input logic ml, input logic mh);
    logic [9:0] idx;
    idx = {b, model_row[b][3:0], col};
    drive("WRITE", C_WR, b, {9'd0, col}, d, ml, mh);
    if (!ml) exp_mem[idx][7:0]  = d[7:0];
    if (!mh) exp_mem[idx][15:8] = d[15:8];
  endtask

  task automatic do_read(input logic [1:0] b, input logic [3:0] col);
    logic [9:0] idx;
    idx = {b, model_row[b][3:0], col};
    drive("READ", C_RD, b, {9'd0, col}, 16'h0, 1'b0, 1'b0);
    sb.push_back('{due: cyc + mcl, data: exp_mem[idx]});
  endtask

  task automatic init_seq();
    drive("PALL", C_PRE, 2'd0, 13'h400, 16'h0, 1'b0, 1'b0);
    drive("REF", C_REF, 2'd0, 13'h0, 16'h0, 1'b0, 1'b0);
    drive("REF", C_REF, 2'd0, 13'h0, 16'h0, 1'b0, 1'b0);
    check_eq("init_before_mrs", init_done, 0);
    do_mrs(13'h020);
    nop(1);
    check_eq("init_done", init_done, 1);
    check_eq("init_refcnt", refresh_count, 2);
    check_eq("init_perr", protocol_error, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    apply_reset();
    mon_en = 1'b1;
    check_eq("rst_init_done", init_done, 0);
    check_eq("rst_perr", protocol_error, 0);
    check_eq("rst_code", error_code, 0);
    check_eq("rst_refcnt", refresh_count, 0);

    // Commands before init: READ flags code 1; later ACT errors do not overwrite it
    drive("READ", C_RD, 2'd0, 13'h0, 16'h0, 1'b0, 1'b0);
    nop(1);
    check_eq("preinit_perr", protocol_error, 1);
    check_eq("preinit_code", error_code, 1);
    drive("ACT", C_ACT, 2'd0, 13'h0, 16'h0, 1'b0, 1'b0);
    drive("ACT", C_ACT, 2'd0, 13'h0, 16'h0, 1'b0, 1'b0);
    nop(1);
    check_eq("preinit_code_sticky", error_code, 1);
    check_eq("preinit_perr_sticky", protocol_error, 1);

    // Clean init, then CL=2 write/read and masked write
    apply_reset();
    check_eq("rst2_perr", protocol_error, 0);
    init_seq();
    do_act(2'd1, 13'd5);
    nop(1);
    do_write(2'd1, 4'd3, 16'hA55A, 1'b0, 1'b0);
    do_read(2'd1, 4'd3);
    nop(3);
    do_write(2'd1, 4'd3, 16'h1234, 1'b0, 1'b1);
    do_read(2'd1, 4'd3);
    nop(3);

    // READ followed immediately by WRITE to the same word returns old data
    do_write(2'd1, 4'd7, 16'h1111, 1'b0, 1'b0);
    do_read(2'd1, 4'd7);
    do_write(2'd1, 4'd7, 16'h2222, 1'b0, 1'b0);
    do_read(2'd1, 4'd7);
    nop(4);

    // CL=3 back-to-back reads, then a read followed by PRE of that bank
    do_mrs(13'h030);
    nop(1);
    do_read(2'd1, 4'd3);
    do_read(2'd1, 4'd7);
    nop(4);
    do_read(2'd1, 4'd3);
    drive("PRE", C_PRE, 2'd1, 13'h000, 16'h0, 1'b0, 1'b0);
    nop(4);
    drive("REF", C_REF, 2'd0, 13'h0, 16'h0, 1'b0, 1'b0);
    nop(1);
    check_eq("refcnt_3", refresh_count, 3);
    check_eq("clean_perr", protocol_error, 0);

    // Reset one edge after a READ cancels its return; storage survives
    do_act(2'd1, 13'd5);
    nop(1);
    do_read(2'd1, 4'd3);
    apply_reset();
    check_eq("midrd_refcnt", refresh_count, 0);
    nop(4);
    init_seq();
    do_act(2'd1, 13'd5);
    nop(1);
    do_read(2'd1, 4'd3);
    nop(3);

    // READ one cycle after ACT: code 5, access still performed
    do_act(2'd0, 13'd0);
    nop(1);
    do_write(2'd0, 4'd0, 16'hBEEF, 1'b0, 1'b0);
    drive("PRE", C_PRE, 2'd0, 13'h000, 16'h0, 1'b0, 1'b0);
    do_act(2'd0, 13'd0);
    do_read(2'd0, 4'd0);
    nop(3);
    check_eq("trcd_code", error_code, 5);
    check_eq("trcd_perr", protocol_error, 1);

    // WRITE sampled while data_oe is high: code 0, write still performed
    apply_reset();
    init_seq();
    do_act(2'd1, 13'd5);
    nop(1);
    do_read(2'd1, 4'd3);
    nop(1);
    do_write(2'd1, 4'd3, 16'h5678, 1'b0, 1'b0);
    nop(1);
    check_eq("conflict_perr", protocol_error, 1);
    check_eq("conflict_code", error_code, 0);
    nop(2);
    do_read(2'd1, 4'd3);
    nop(3);
    do_act(2'd1, 13'd5);
    nop(1);
    check_eq("conflict_code_sticky", error_code, 0);

    // Unsupported MRS keeps the init FSM waiting and flags code 2
    apply_reset();
    drive("PALL", C_PRE, 2'd0, 13'h400, 16'h0, 1'b0, 1'b0);
    drive("REF", C_REF, 2'd0, 13'h0, 16'h0, 1'b0, 1'b0);
    drive("REF", C_REF, 2'd0, 13'h0, 16'h0, 1'b0, 1'b0);
    do_mrs(13'h040);
    nop(1);
    check_eq("badmrs_code", error_code, 2);
    check_eq("badmrs_init", init_done, 0);
    do_mrs(13'h020);
    nop(1);
    check_eq("goodmrs_init", init_done, 1);

    nop(6);
    check_eq("sb_drain", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
